instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the pipelined LEGv8 processor: holds the program counter, drives the word address into the instruction ROM, and captures the returned instruction into the IF/ID pipeline register. It honours hazard stalls and pipeline flushes, redirects on taken branches, and stops fetching cleanly past a programmed end address. It sits directly upstream of decode and is the only driver of the ROM address.

## Interface
- ADDR_W, 16, PC / ROM word-address width
- INSTR_W, 32, instruction width
- RESET_PC, 16'h0000, PC value after reset
- PC_LIMIT, 16'hFFFF, last fetchable word address; PC above this halts fetch

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- rom_addr  out  ADDR_W  word address to instruction ROM (combinational from PC)
- rom_data  in  INSTR_W  instruction returned combinationally by ROM for rom_addr
- stall  in  1  hazard unit: hold PC and IF/ID
- flush  in  1  squash IF/ID contents
- branch_taken  in  1  redirect PC this cycle
- branch_target  in  ADDR_W  word address to redirect to
- if_id_instr  out  INSTR_W  registered instruction to decode
- if_id_pc  out  ADDR_W  registered PC of if_id_instr
- if_id_valid  out  1  if_id_instr is a real fetched instruction (0 = bubble)
- halted  out  1  fetch stopped: PC > PC_LIMIT
- fetch_count  out  32  count of instructions latched valid into IF/ID

## Operation
- rom_addr = pc at all times; PC is a word address and increments by 1.
- Per-edge priority: reset > branch_taken > flush > stall > halted > normal.
- branch_taken: pc <= branch_target; IF/ID <= bubble (instr 0, pc 0, valid 0). Applies even when stall or flush is high. Clears halted if branch_target <= PC_LIMIT.
- flush (no branch): IF/ID <= bubble; pc holds, so the instruction at pc is refetched next cycle.
- stall (no branch/flush): pc, IF/ID, fetch_count hold.
- halted (pc > PC_LIMIT): IF/ID <= bubble; pc holds; fetch_count holds.
- normal: IF/ID <= {rom_data, pc, valid=1}; pc <= pc + 1, wrapping modulo 2^ADDR_W (only reachable when PC_LIMIT = all-ones).
- halted is combinational from pc: halted = (pc > PC_LIMIT).
- fetch_count increments by 1 on every edge that latches valid=1; saturates at 32'hFFFF_FFFF.
- Bubble encoding is all-zero instruction (the NOP encoding at address 0).

## Timing
- Reset (async assert, any time, including mid-stall or mid-branch): pc = RESET_PC, if_id_instr = 0, if_id_pc = 0, if_id_valid = 0, fetch_count = 0; halted reflects RESET_PC > PC_LIMIT. Release synchronised by the system; the first edge after release performs a normal fetch of RESET_PC.
- Fetch latency: instruction at pc appears on if_id_* one edge later.
- Branch: branch_taken high in the cycle ending at edge n -> pc = target after n; target instruction valid in IF/ID after edge n+1; exactly one bubble after the redirect edge.
- stall held k cycles: outputs frozen for k edges, then resume with no loss or duplication.
- stall and flush together: flush wins (bubble, pc holds).
- Fetch of pc = PC_LIMIT is valid; the next pc exceeds the limit and halted asserts after that edge.

## Test plan
- Reset/linear fetch: bench ROM {0:0, 1:F8400081, 2:F8401082, 3:8B020023}, RESET_PC=0, PC_LIMIT=3 -> IF/ID shows (0,0),(1,F8400081),(2,F8401082),(3,8B020023) valid on successive edges; halted=1 after 4th edge, fetch_count=4, IF/ID then bubbles.
- Stall: assert stall 2 cycles while IF/ID holds pc 1 -> if_id_pc stays 1, rom_addr stays 2 for two edges, then pc 2 latched; fetch_count unchanged during stall.
- Branch over stall: at pc 3 assert branch_taken, target 1, stall=1 -> next edge IF/ID bubble, pc=1; following edge IF/ID = (1,F8400081); halted clears.
- Flush: flush one cycle with pc=2 -> IF/ID bubble, next edge (2,F8401082) valid; no instruction skipped.
- Async reset mid-run: drop reset_n between edges with pc=2 -> outputs zero immediately, pc=0, fetch_count=0, without waiting for clk.
- Wraparound: PC_LIMIT=16'hFFFF, branch to 16'hFFFF -> fetch of FFFF valid, next pc=0000, halted never asserts.

Source files
------------

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage of the pipelined LEGv8 core. Owns the program counter, presents
// it as the word address to the instruction ROM, and captures the returned
// instruction into the IF/ID pipeline register for decode.
//
// Parameters:
//   ADDR_W   - PC / ROM word-address width
//   INSTR_W  - instruction width
//   RESET_PC - PC value after reset
//   PC_LIMIT - last fetchable word address; a PC above it stops fetching
//
// Ports:
//   clk           in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   rom_addr      out  word address to the ROM (always equal to the PC)
//   rom_data      in   instruction returned combinationally for rom_addr
//   stall         in   hazard hold: PC, IF/ID and fetch_count keep their value
//   flush         in   squash IF/ID; the PC holds so its instruction is refetched
//   branch_taken  in   redirect the PC to branch_target this edge
//   branch_target in   word address to redirect to
//   if_id_instr   out  registered instruction for decode
//   if_id_pc      out  registered PC of if_id_instr
//   if_id_valid   out  1 = real fetched instruction, 0 = bubble
//   halted        out  PC is beyond PC_LIMIT (combinational from the PC)
//   fetch_count   out  saturating count of valid instructions latched into IF/ID
// ----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int                 ADDR_W   = 16,
    parameter int                 INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = 16'h0000,
    parameter logic [ADDR_W-1:0]  PC_LIMIT = 16'hFFFF
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               stall,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic               if_id_valid,
    output logic               halted,
    output logic [31:0]        fetch_count
);

    // What the stage does on the coming edge, already resolved by priority.
    typedef enum logic [2:0] {
        ACT_FETCH  = 3'd0,
        ACT_BRANCH = 3'd1,
        ACT_FLUSH  = 3'd2,
        ACT_STALL  = 3'd3,
        ACT_HALT   = 3'd4
    } act_t;

    localparam logic [ADDR_W-1:0]  PC_ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [INSTR_W-1:0] BUBBLE_INSTR = {INSTR_W{1'b0}};
    localparam logic [ADDR_W-1:0]  BUBBLE_PC    = {ADDR_W{1'b0}};

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

    logic [ADDR_W-1:0]  pc_r;
    logic [INSTR_W-1:0] instr_r;
    logic [ADDR_W-1:0]  ifpc_r;
    logic               valid_r;
    logic [31:0]        count_r;

    act_t               act_s;
    logic               halted_s;
    logic [ADDR_W-1:0]  pc_next_s;
    logic [INSTR_W-1:0] instr_next_s;
    logic [ADDR_W-1:0]  ifpc_next_s;
    logic               valid_next_s;
    logic [31:0]        count_next_s;

    // The comparison is widened by one bit so it stays a real compare even
    // when PC_LIMIT is the all-ones address (halted can then never assert).
    assign halted_s = ({1'b0, pc_r} > {1'b0, PC_LIMIT});

    // Priority resolution: branch > flush > stall > halted > normal fetch.
    always_comb begin
        act_s = ACT_FETCH;
        if (branch_taken) begin
            act_s = ACT_BRANCH;
        end else if (flush) begin
            act_s = ACT_FLUSH;
        end else if (stall) begin
            act_s = ACT_STALL;
        end else if (halted_s) begin
            act_s = ACT_HALT;
        end else begin
            act_s = ACT_FETCH;
        end
    end

    // Next-state values of the PC, the IF/ID register and the fetch counter.
    always_comb begin
        pc_next_s    = pc_r;
        instr_next_s = instr_r;
        ifpc_next_s  = ifpc_r;
        valid_next_s = valid_r;
        count_next_s = count_r;
        case (act_s)
            ACT_BRANCH: begin
                // Redirect; whatever was being fetched this cycle is on the
                // wrong path, so decode sees exactly one bubble.
                pc_next_s    = branch_target;
                instr_next_s = BUBBLE_INSTR;
                ifpc_next_s  = BUBBLE_PC;
                valid_next_s = 1'b0;
            end
            ACT_FLUSH: begin
                // PC holds, so the squashed instruction is fetched again.
                instr_next_s = BUBBLE_INSTR;
                ifpc_next_s  = BUBBLE_PC;
                valid_next_s = 1'b0;
            end
            ACT_STALL: begin
                pc_next_s    = pc_r;
                instr_next_s = instr_r;
                ifpc_next_s  = ifpc_r;
                valid_next_s = valid_r;
            end
            ACT_HALT: begin
                instr_next_s = BUBBLE_INSTR;
                ifpc_next_s  = BUBBLE_PC;
                valid_next_s = 1'b0;
            end
            ACT_FETCH: begin
                // PC wraps modulo 2^ADDR_W; only reachable with an all-ones limit.
                pc_next_s    = pc_r + PC_ONE;
                instr_next_s = rom_data;
                ifpc_next_s  = pc_r;
                valid_next_s = 1'b1;
                count_next_s = sat_inc(count_r);
            end
            default: begin
                instr_next_s = BUBBLE_INSTR;
                ifpc_next_s  = BUBBLE_PC;
                valid_next_s = 1'b0;
            end
        endcase
    end

    // PC register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_r <= BUBBLE_INSTR;
            ifpc_r  <= BUBBLE_PC;
            valid_r <= 1'b0;
        end else begin
            instr_r <= instr_next_s;
            ifpc_r  <= ifpc_next_s;
            valid_r <= valid_next_s;
        end
    end

    // Count of valid instructions handed to decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= 32'd0;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign rom_addr    = pc_r;
    assign halted      = halted_s;
    assign if_id_instr = instr_r;
    assign if_id_pc    = ifpc_r;
    assign if_id_valid = valid_r;
    assign fetch_count = count_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Two instances: dut_a (PC_LIMIT = 3) with a four-word ROM for linear fetch,
// stall, branch, flush and async reset; dut_b (PC_LIMIT = all-ones) for PC
// wraparound. Expected valid IF/ID entries for dut_a are queued by the
// stimulus and consumed by a monitor whenever a new valid entry is latched.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n_a, stall_a, flush_a, branch_a;
    logic [15:0] target_a, rom_addr_a, if_id_pc_a;
    logic [31:0] rom_data_a, if_id_instr_a, fetch_count_a;
    logic        if_id_valid_a, halted_a;

    logic        reset_n_b, stall_b, flush_b, branch_b;
    logic [15:0] target_b, rom_addr_b, if_id_pc_b;
    logic [31:0] rom_data_b, if_id_instr_b, fetch_count_b;
    logic        if_id_valid_b, halted_b;

    function automatic logic [31:0] rom_a(input logic [15:0] a);
        logic [31:0] d;
        case (a)
            16'd1:   d = 32'hF840_0081;
            16'd2:   d = 32'hF840_1082;
            16'd3:   d = 32'h8B02_0023;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    assign rom_data_a = rom_a(rom_addr_a);
    assign rom_data_b = {16'hA5A5, rom_addr_b};

    instruction_fetch #(
        .ADDR_W(16), .INSTR_W(32), .RESET_PC(16'h0000), .PC_LIMIT(16'h0003)
    ) dut_a (
        .clk(clk), .reset_n(reset_n_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .stall(stall_a), .flush(flush_a), .branch_taken(branch_a), .branch_target(target_a),
        .if_id_instr(if_id_instr_a), .if_id_pc(if_id_pc_a), .if_id_valid(if_id_valid_a),
        .halted(halted_a), .fetch_count(fetch_count_a)
    );

    instruction_fetch #(
        .ADDR_W(16), .INSTR_W(32), .RESET_PC(16'h0000), .PC_LIMIT(16'hFFFF)
    ) dut_b (
        .clk(clk), .reset_n(reset_n_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .stall(stall_b), .flush(flush_b), .branch_taken(branch_b), .branch_target(target_b),
        .if_id_instr(if_id_instr_b), .if_id_pc(if_id_pc_b), .if_id_valid(if_id_valid_b),
        .halted(halted_b), .fetch_count(fetch_count_b)
    );

    typedef struct {
        logic [31:0] instr;
        logic [15:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        sb_q.push_back(e);
    endtask

    // Monitor: a valid IF/ID entry after an edge with stall low is a new latch.
    initial begin : monitor
        logic stall_cap;
        logic rst_cap;
        exp_t e;
        forever begin
            @(posedge clk);
            stall_cap = stall_a;
            rst_cap   = reset_n_a;
            #1;
            if (rst_cap && reset_n_a && if_id_valid_a && !stall_cap) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got pc %h instr %h, want no entry", if_id_pc_a, if_id_instr_a);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_pc", {16'h0000, if_id_pc_a}, {16'h0000, e.pc});
                    chk("sb_instr", if_id_instr_a, e.instr);
                end
            end
        end
    end

    initial begin
        reset_n_a = 1'b0; stall_a = 1'b0; flush_a = 1'b0; branch_a = 1'b0; target_a = 16'h0000;
        reset_n_b = 1'b0; stall_b = 1'b0; flush_b = 1'b0; branch_b = 1'b0; target_b = 16'h0000;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_instr", if_id_instr_a, 32'h0);
        chk("rst_pc", {16'h0, if_id_pc_a}, 32'h0);
        chk("rst_valid", {31'h0, if_id_valid_a}, 32'h0);
        chk("rst_count", fetch_count_a, 32'h0);
        chk("rst_addr", {16'h0, rom_addr_a}, 32'h0);
        chk("rst_halted", {31'h0, halted_a}, 32'h0);

        // Linear fetch up to the limit
        reset_n_a = 1'b1;
        push(16'd0, 32'h0000_0000);
        push(16'd1, 32'hF840_0081);
        push(16'd2, 32'hF840_1082);
        push(16'd3, 32'h8B02_0023);
        repeat (4) @(negedge clk);
        chk("lin_halted", {31'h0, halted_a}, 32'h1);
        chk("lin_count", fetch_count_a, 32'd4);
        chk("lin_addr", {16'h0, rom_addr_a}, 32'd4);
        @(negedge clk);
        chk("halt_valid", {31'h0, if_id_valid_a}, 32'h0);
        chk("halt_instr", if_id_instr_a, 32'h0);
        chk("halt_count", fetch_count_a, 32'd4);
        chk("halt_addr", {16'h0, rom_addr_a}, 32'd4);

        // Reset again, then stall while IF/ID holds pc 1
        reset_n_a = 1'b0;
        #1;
        chk("rr_addr", {16'h0, rom_addr_a}, 32'h0);
        chk("rr_count", fetch_count_a, 32'h0);
        @(negedge clk);
        reset_n_a = 1'b1;
        push(16'd0, 32'h0000_0000);
        push(16'd1, 32'hF840_0081);
        repeat (2) @(negedge clk);
        stall_a = 1'b1;
        chk("st_addr", {16'h0, rom_addr_a}, 32'd2);
        chk("st_pc", {16'h0, if_id_pc_a}, 32'd1);
        chk("st_count", fetch_count_a, 32'd2);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("st_hold_pc", {16'h0, if_id_pc_a}, 32'd1);
            chk("st_hold_addr", {16'h0, rom_addr_a}, 32'd2);
            chk("st_hold_count", fetch_count_a, 32'd2);
            chk("st_hold_valid", {31'h0, if_id_valid_a}, 32'h1);
        end
        stall_a = 1'b0;
        push(16'd2, 32'hF840_1082);
        @(negedge clk);
        chk("st_resume_count", fetch_count_a, 32'd3);
        chk("st_resume_addr", {16'h0, rom_addr_a}, 32'd3);
        push(16'd3, 32'h8B02_0023);
        @(negedge clk);
        chk("pre_br_halted", {31'h0, halted_a}, 32'h1);
        chk("pre_br_count", fetch_count_a, 32'd4);
        @(negedge clk);
        chk("pre_br_bubble", {31'h0, if_id_valid_a}, 32'h0);

        // Branch to 1 while stalled and halted
        branch_a = 1'b1; target_a = 16'd1; stall_a = 1'b1;
        @(negedge clk);
        chk("br_valid", {31'h0, if_id_valid_a}, 32'h0);
        chk("br_instr", if_id_instr_a, 32'h0);
        chk("br_pc", {16'h0, if_id_pc_a}, 32'h0);
        chk("br_addr", {16'h0, rom_addr_a}, 32'd1);
        chk("br_halted", {31'h0, halted_a}, 32'h0);
        chk("br_count", fetch_count_a, 32'd4);
        branch_a = 1'b0; stall_a = 1'b0;
        push(16'd1, 32'hF840_0081);
        @(negedge clk);
        chk("br_tgt_count", fetch_count_a, 32'd5);
        chk("br_tgt_addr", {16'h0, rom_addr_a}, 32'd2);

        // Flush at pc 2: bubble, then pc 2 refetched
        flush_a = 1'b1;
        @(negedge clk);
        chk("fl_valid", {31'h0, if_id_valid_a}, 32'h0);
        chk("fl_addr", {16'h0, rom_addr_a}, 32'd2);
        chk("fl_count", fetch_count_a, 32'd5);
        flush_a = 1'b0;
        push(16'd2, 32'hF840_1082);
        @(negedge clk);
        chk("fl_count2", fetch_count_a, 32'd6);
        chk("fl_addr2", {16'h0, rom_addr_a}, 32'd3);

        // Stall and flush together: flush wins
        flush_a = 1'b1; stall_a = 1'b1;
        @(negedge clk);
        chk("sf_valid", {31'h0, if_id_valid_a}, 32'h0);
        chk("sf_instr", if_id_instr_a, 32'h0);
        chk("sf_addr", {16'h0, rom_addr_a}, 32'd3);
        chk("sf_count", fetch_count_a, 32'd6);
        flush_a = 1'b0; stall_a = 1'b0;
        push(16'd3, 32'h8B02_0023);
        @(negedge clk);
        chk("sf_count2", fetch_count_a, 32'd7);
        chk("sf_halted", {31'h0, halted_a}, 32'h1);

        // Get pc 2 with a valid IF/ID, then drop reset between edges
        branch_a = 1'b1; target_a = 16'd1;
        @(negedge clk);
        chk("ar_pre_addr", {16'h0, rom_addr_a}, 32'd1);
        branch_a = 1'b0;
        push(16'd1, 32'hF840_0081);
        @(negedge clk);
        chk("ar_pre_count", fetch_count_a, 32'd8);
        chk("ar_pre_addr2", {16'h0, rom_addr_a}, 32'd2);
        #2;
        reset_n_a = 1'b0;
        #1;
        chk("ar_instr", if_id_instr_a, 32'h0);
        chk("ar_pc", {16'h0, if_id_pc_a}, 32'h0);
        chk("ar_valid", {31'h0, if_id_valid_a}, 32'h0);
        chk("ar_count", fetch_count_a, 32'h0);
        chk("ar_addr", {16'h0, rom_addr_a}, 32'h0);
        chk("ar_halted", {31'h0, halted_a}, 32'h0);
        @(negedge clk);
        reset_n_a = 1'b1;
        push(16'd0, 32'h0000_0000);
        @(negedge clk);
        chk("ar_resume_count", fetch_count_a, 32'd1);
        chk("ar_resume_addr", {16'h0, rom_addr_a}, 32'd1);
        stall_a = 1'b1;

        // Wraparound on dut_b
        reset_n_b = 1'b1; branch_b = 1'b1; target_b = 16'hFFFF;
        @(negedge clk);
        chk("wr_addr", {16'h0, rom_addr_b}, 32'h0000_FFFF);
        chk("wr_valid", {31'h0, if_id_valid_b}, 32'h0);
        chk("wr_halted", {31'h0, halted_b}, 32'h0);
        chk("wr_count", fetch_count_b, 32'h0);
        branch_b = 1'b0;
        @(negedge clk);
        chk("wr_pc", {16'h0, if_id_pc_b}, 32'h0000_FFFF);
        chk("wr_instr", if_id_instr_b, 32'hA5A5_FFFF);
        chk("wr_valid2", {31'h0, if_id_valid_b}, 32'h1);
        chk("wr_addr2", {16'h0, rom_addr_b}, 32'h0);
        chk("wr_halted2", {31'h0, halted_b}, 32'h0);
        chk("wr_count2", fetch_count_b, 32'd1);
        @(negedge clk);
        chk("wr_pc3", {16'h0, if_id_pc_b}, 32'h0);
        chk("wr_instr3", if_id_instr_b, 32'hA5A5_0000);
        chk("wr_halted3", {31'h0, halted_b}, 32'h0);
        chk("wr_count3", fetch_count_b, 32'd2);

        chk("sb_drain", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
